// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat: conditions raw active-low pushbuttons.
// Each key passes through a two-flop synchroniser and a debounce filter.
// The outputs per key are a debounced level, a one-cycle press pulse and a
// one-cycle release pulse. An optional auto-repeat re-issues the press
// pulse while the key stays held.
module key_debounce_repeat #(
    parameter int N_KEYS          = 4,
    parameter int CNT_W           = 25,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] KEY,
    input  logic              repeat_en,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] key_s;

    // Two-flop synchroniser; idles at 1 (released) so reset looks like no key held.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= {N_KEYS{1'b1}};
            sync2 <= {N_KEYS{1'b1}};
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    assign key_s = ~sync2;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi = gi + 1) begin : g_key
            logic [CNT_W-1:0] db_cnt;
            logic [CNT_W-1:0] rep_cnt;
            rep_state_t       state;
            logic             level;
            logic             ppulse;
            logic             rpulse;
            logic             mismatch;
            logic             toggle;
            logic             rise;
            logic             fall;

            // Decode when the debounced level is about to flip and in which direction.
            always_comb begin
                mismatch = (key_s[gi] != level);
                toggle   = mismatch && (db_cnt == DB_LAST);
                rise     = toggle && !level;
                fall     = toggle && level;
            end

            // Debounce counter, debounced level, and the repeat FSM with registered pulses.
            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    db_cnt  <= CNT_ZERO;
                    rep_cnt <= CNT_ZERO;
                    state   <= IDLE;
                    level   <= 1'b0;
                    ppulse  <= 1'b0;
                    rpulse  <= 1'b0;
                end else begin
                    // Debounce: any agreement clears the count, so glitches shorter
                    // than DEBOUNCE_CYCLES never reach the level.
                    if (!mismatch) begin
                        db_cnt <= CNT_ZERO;
                    end else if (toggle) begin
                        db_cnt <= CNT_ZERO;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end

                    if (toggle) begin
                        level <= ~level;
                    end else begin
                        level <= level;
                    end

                    ppulse <= 1'b0;
                    rpulse <= fall;

                    // A release takes priority over any repeat due on the same cycle.
                    if (fall) begin
                        state   <= IDLE;
                        rep_cnt <= CNT_ZERO;
                    end else begin
                        case (state)
                            IDLE: begin
                                rep_cnt <= CNT_ZERO;
                                if (rise) begin
                                    ppulse <= 1'b1;
                                    state  <= DELAY;
                                end else begin
                                    state  <= IDLE;
                                end
                            end
                            DELAY: begin
                                if (!repeat_en) begin
                                    rep_cnt <= CNT_ZERO;
                                    state   <= DELAY;
                                end else if (rep_cnt == RD_LAST) begin
                                    ppulse  <= 1'b1;
                                    rep_cnt <= CNT_ZERO;
                                    state   <= REPEAT;
                                end else begin
                                    rep_cnt <= rep_cnt + CNT_ONE;
                                    state   <= DELAY;
                                end
                            end
                            REPEAT: begin
                                if (!repeat_en) begin
                                    rep_cnt <= CNT_ZERO;
                                    state   <= DELAY;
                                end else if (rep_cnt == RP_LAST) begin
                                    ppulse  <= 1'b1;
                                    rep_cnt <= CNT_ZERO;
                                    state   <= REPEAT;
                                end else begin
                                    rep_cnt <= rep_cnt + CNT_ONE;
                                    state   <= REPEAT;
                                end
                            end
                            default: begin
                                rep_cnt <= CNT_ZERO;
                                state   <= IDLE;
                            end
                        endcase
                    end
                end
            end

            assign pressed[gi]       = level;
            assign press_pulse[gi]   = ppulse;
            assign release_pulse[gi] = rpulse;
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Table-driven bench for key_debounce_repeat with small counts:
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_debounce_repeat;

    logic       clk;
    logic       reset;
    logic [3:0] key;
    logic       repeat_en;
    logic [3:0] pressed;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

    int errors = 0;
    int checks = 0;

    key_debounce_repeat #(
        .N_KEYS(4),
        .CNT_W(25),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .KEY(key),
        .repeat_en(repeat_en),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record covers n consecutive cycles with the same inputs and expectations.
    typedef struct {
        int         n;
        logic [3:0] key;
        logic       en;
        logic [3:0] p;
        logic [3:0] pp;
        logic [3:0] rp;
    } row_t;

    row_t rows[$];

    task automatic add(input int n, input logic [3:0] k, input logic en,
                       input logic [3:0] p, input logic [3:0] pp, input logic [3:0] rp);
        row_t r;
        r.n = n; r.key = k; r.en = en; r.p = p; r.pp = pp; r.rp = rp;
        rows.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        int step;
        reset     = 1'b1;
        key       = 4'b1111;
        repeat_en = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pressed", 0, pressed, 4'b0000);
        chk("reset_press_pulse", 0, press_pulse, 4'b0000);
        chk("reset_release_pulse", 0, release_pulse, 4'b0000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: single press of KEY[0], then release (repeat off)
        add(5, 4'b1110, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1110, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        add(3, 4'b1110, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        add(5, 4'b1111, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0001);
        add(2, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        // Test 2: bounce on KEY[1]: 3 low, 1 high, then low
        add(3, 4'b1101, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(5, 4'b1101, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1101, 1'b0, 4'b0010, 4'b0010, 4'b0000);
        add(3, 4'b1101, 1'b0, 4'b0010, 4'b0000, 4'b0000);
        add(5, 4'b1111, 1'b0, 4'b0010, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0010);
        add(2, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        // Test 4: repeat off, hold KEY[3] for 40 cycles
        add(5, 4'b0111, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0111, 1'b0, 4'b1000, 4'b1000, 4'b0000);
        add(34, 4'b0111, 1'b0, 4'b1000, 4'b0000, 4'b0000);
        add(5, 4'b1111, 1'b0, 4'b1000, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b1000);
        add(2, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        // Test 5: KEY[0] and KEY[3] together
        add(5, 4'b0110, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0110, 1'b0, 4'b1001, 4'b1001, 4'b0000);
        add(2, 4'b0110, 1'b0, 4'b1001, 4'b0000, 4'b0000);
        add(5, 4'b1111, 1'b0, 4'b1001, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b1001);
        add(2, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        // Test 3: repeat on, hold KEY[2]; pulses at t0, t0+10, t0+13, t0+16, t0+19,
        // release lands at t0+22 where a repeat would otherwise fire
        add(5, 4'b1011, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1011, 1'b1, 4'b0100, 4'b0100, 4'b0000);
        add(9, 4'b1011, 1'b1, 4'b0100, 4'b0000, 4'b0000);
        add(1, 4'b1011, 1'b1, 4'b0100, 4'b0100, 4'b0000);
        add(2, 4'b1011, 1'b1, 4'b0100, 4'b0000, 4'b0000);
        add(1, 4'b1011, 1'b1, 4'b0100, 4'b0100, 4'b0000);
        add(2, 4'b1011, 1'b1, 4'b0100, 4'b0000, 4'b0000);
        add(1, 4'b1011, 1'b1, 4'b0100, 4'b0100, 4'b0000);
        add(2, 4'b1111, 1'b1, 4'b0100, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1'b1, 4'b0100, 4'b0100, 4'b0000);
        add(2, 4'b1111, 1'b1, 4'b0100, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b0100);
        add(6, 4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b0000);

        step = 0;
        foreach (rows[r]) begin
            for (int c = 0; c < rows[r].n; c++) begin
                key       = rows[r].key;
                repeat_en = rows[r].en;
                @(posedge clk);
                @(negedge clk);
                chk("pressed", step, pressed, rows[r].p);
                chk("press_pulse", step, press_pulse, rows[r].pp);
                chk("release_pulse", step, release_pulse, rows[r].rp);
                step++;
            end
        end

        // Test 6: reset mid-repeat, KEY[2] still held across deassertion
        key       = 4'b1011;
        repeat_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("pre_reset_pressed", 0, pressed, 4'b0100);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_pressed", 0, pressed, 4'b0000);
        chk("async_reset_press_pulse", 0, press_pulse, 4'b0000);
        chk("async_reset_release_pulse", 0, release_pulse, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_reset_press_pulse", e, press_pulse, (e == 6) ? 4'b0100 : 4'b0000);
            chk("post_reset_pressed", e, pressed, (e == 6) ? 4'b0100 : 4'b0000);
        end
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_pulse_width", 7, press_pulse, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
